reg_file_dual_wr: RTL and testbench

REG_FILE_DUAL_WR -- requirements
Module: reg_file_dual_wr

---
 rtl/reg_file_dual_wr.sv | 101 ++++++++++
 tb/tb_reg_file_dual_wr.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_dual_wr.sv
// Dual-write-port register file with asynchronous reads, optional write bypass
// and a per-register pending scoreboard.
module reg_file_dual_wr #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] regDst1,
    input  logic [WIDTH-1:0]  bus_w,
    input  logic              regWrite2,
    input  logic [ADDR_W-1:0] regDst2,
    input  logic [WIDTH-1:0]  bus2_w,
    input  logic [ADDR_W-1:0] regSrc1,
    input  logic [ADDR_W-1:0] regSrc2,
    output logic [WIDTH-1:0]  out1,
    output logic [WIDTH-1:0]  out2,
    input  logic              mark,
    input  logic [ADDR_W-1:0] markDst,
    output logic              busy1,
    output logic              busy2,
    output logic              wr_conflict
);

    localparam int DEPTH  = 2**ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 0);
    localparam bit BYP_EN  = (BYPASS != 0);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] pending;

    logic we1, we2, markEn;
    logic [WIDTH-1:0] rdData [2];
    logic             rdBusy [2];

    // Address 0 is masked here so every downstream use sees it as inert.
    always_comb begin
        we1    = regWrite  && !(ZERO_EN && (regDst1 == '0));
        we2    = regWrite2 && !(ZERO_EN && (regDst2 == '0));
        markEn = mark      && !(ZERO_EN && (markDst == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            pending     <= '0;
            wr_conflict <= 1'b0;
        end else begin
            // Port 1 is assigned last so it wins an address collision.
            if (we2) regs[regDst2] <= bus2_w;
            if (we1) regs[regDst1] <= bus_w;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (markEn && (markDst == ADDR_W'(i))) begin
                    pending[i] <= 1'b1;
                end else if ((we1 && (regDst1 == ADDR_W'(i))) ||
                             (we2 && (regDst2 == ADDR_W'(i)))) begin
                    pending[i] <= 1'b0;
                end
            end
            wr_conflict <= we1 && we2 && (regDst1 == regDst2);
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] src;
        logic hit1, hit2, hitM;
        for (int unsigned p = 0; p < 2; p++) begin
            src  = (p == 0) ? regSrc1 : regSrc2;
            hit1 = we1 && (regDst1 == src);
            hit2 = we2 && (regDst2 == src);
            hitM = markEn && (markDst == src);
            rdData[p] = regs[src];
            rdBusy[p] = pending[src];
            if (BYP_EN) begin
                if (hit1) begin
                    rdData[p] = bus_w;
                end else if (hit2) begin
                    rdData[p] = bus2_w;
                end
                if ((hit1 || hit2) && !hitM) begin
                    rdBusy[p] = 1'b0;
                end
            end
            if (ZERO_EN && (src == '0)) begin
                rdData[p] = '0;
                rdBusy[p] = 1'b0;
            end
        end
    end

    assign out1  = rdData[0];
    assign out2  = rdData[1];
    assign busy1 = rdBusy[0];
    assign busy2 = rdBusy[1];

endmodule

// File: tb/tb_reg_file_dual_wr.sv
// Directed plus random bench for reg_file_dual_wr in two configurations
// (A: ZERO_REG=0/BYPASS=1, B: ZERO_REG=1/BYPASS=0) sharing one stimulus.
module tb_reg_file_dual_wr;

    logic        clk = 1'b0;
    logic        rst, regWrite, regWrite2, mark;
    logic [3:0]  regDst1, regDst2, regSrc1, regSrc2, markDst;
    logic [31:0] bus_w, bus2_w;
    logic [31:0] outA1, outA2, outB1, outB2;
    logic        busyA1, busyA2, busyB1, busyB2, confA, confB;

    int passCount = 0;
    int failCount = 0;
    int total     = 0;

    // Reference model state, index 0 = config A, 1 = config B
    logic [31:0] mem  [2][16];
    bit          pend [2][16];
    bit          conf [2];
    bit          zr   [2];
    bit          byp  [2];

    always #5 clk = ~clk;

    reg_file_dual_wr #(.WIDTH(32), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) dutA (
        .clk(clk), .rst(rst),
        .regWrite(regWrite), .regDst1(regDst1), .bus_w(bus_w),
        .regWrite2(regWrite2), .regDst2(regDst2), .bus2_w(bus2_w),
        .regSrc1(regSrc1), .regSrc2(regSrc2), .out1(outA1), .out2(outA2),
        .mark(mark), .markDst(markDst), .busy1(busyA1), .busy2(busyA2),
        .wr_conflict(confA)
    );

    reg_file_dual_wr #(.WIDTH(32), .ADDR_W(4), .ZERO_REG(1), .BYPASS(0)) dutB (
        .clk(clk), .rst(rst),
        .regWrite(regWrite), .regDst1(regDst1), .bus_w(bus_w),
        .regWrite2(regWrite2), .regDst2(regDst2), .bus2_w(bus2_w),
        .regSrc1(regSrc1), .regSrc2(regSrc2), .out1(outB1), .out2(outB2),
        .mark(mark), .markDst(markDst), .busy1(busyB1), .busy2(busyB2),
        .wr_conflict(confB)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mOut(input int c, input logic [3:0] s);
        if (zr[c] && s == 4'd0) return 32'h0;
        if (byp[c] && regWrite && !(zr[c] && regDst1 == 4'd0) && regDst1 == s) return bus_w;
        if (byp[c] && regWrite2 && !(zr[c] && regDst2 == 4'd0) && regDst2 == s) return bus2_w;
        return mem[c][s];
    endfunction

    function automatic logic mBusy(input int c, input logic [3:0] s);
        bit written;
        if (zr[c] && s == 4'd0) return 1'b0;
        written = (regWrite && regDst1 == s) || (regWrite2 && regDst2 == s);
        if (byp[c] && written && !(mark && markDst == s)) return 1'b0;
        return pend[c][s];
    endfunction

    task automatic modelEdge();
        bit v1, v2, vm;
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                for (int a = 0; a < 16; a++) begin
                    mem[c][a]  = 32'h0;
                    pend[c][a] = 1'b0;
                end
                conf[c] = 1'b0;
            end else begin
                v1 = regWrite  && !(zr[c] && regDst1 == 4'd0);
                v2 = regWrite2 && !(zr[c] && regDst2 == 4'd0);
                vm = mark      && !(zr[c] && markDst == 4'd0);
                conf[c] = v1 && v2 && (regDst1 == regDst2);
                if (v2) mem[c][regDst2] = bus2_w;
                if (v1) mem[c][regDst1] = bus_w;
                if (v1) pend[c][regDst1] = 1'b0;
                if (v2) pend[c][regDst2] = 1'b0;
                if (vm) pend[c][markDst] = 1'b1;
            end
        end
    endtask

    // Inputs are set just after a rising edge; this checks the combinational
    // outputs, crosses the edge, then checks the registered conflict flag.
    task automatic step();
        #4;
        chk($sformatf("A.out1[%0d]", regSrc1), outA1, mOut(0, regSrc1));
        chk($sformatf("A.out2[%0d]", regSrc2), outA2, mOut(0, regSrc2));
        chk($sformatf("B.out1[%0d]", regSrc1), outB1, mOut(1, regSrc1));
        chk($sformatf("B.out2[%0d]", regSrc2), outB2, mOut(1, regSrc2));
        chk($sformatf("A.busy1[%0d]", regSrc1), {31'b0, busyA1}, {31'b0, mBusy(0, regSrc1)});
        chk($sformatf("A.busy2[%0d]", regSrc2), {31'b0, busyA2}, {31'b0, mBusy(0, regSrc2)});
        chk($sformatf("B.busy1[%0d]", regSrc1), {31'b0, busyB1}, {31'b0, mBusy(1, regSrc1)});
        chk($sformatf("B.busy2[%0d]", regSrc2), {31'b0, busyB2}, {31'b0, mBusy(1, regSrc2)});
        @(posedge clk);
        modelEdge();
        #1;
        chk("A.wr_conflict", {31'b0, confA}, {31'b0, conf[0]});
        chk("B.wr_conflict", {31'b0, confB}, {31'b0, conf[1]});
    endtask

    task automatic idle();
        rst = 1'b0; regWrite = 1'b0; regWrite2 = 1'b0; mark = 1'b0;
    endtask

    initial begin
        zr[0] = 1'b0; byp[0] = 1'b1;
        zr[1] = 1'b1; byp[1] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            conf[c] = 1'b0;
            for (int a = 0; a < 16; a++) begin
                mem[c][a] = 32'hX; pend[c][a] = 1'b0;
            end
        end
        idle();
        regDst1 = 4'd0; regDst2 = 4'd0; markDst = 4'd0;
        regSrc1 = 4'd0; regSrc2 = 4'd0; bus_w = 32'h0; bus2_w = 32'h0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        step();

        // Every address reads zero and idle after reset
        idle();
        for (int s = 0; s < 16; s++) begin
            regSrc1 = 4'(s); regSrc2 = 4'(15 - s);
            #2;
            chk("rst.out1", outA1, 32'h0);
            chk("rst.busy2", {31'b0, busyB2}, 32'h0);
            step();
        end

        // Two independent writes in one edge
        regWrite = 1'b1;  regDst1 = 4'd3; bus_w  = 32'hAAAA0001;
        regWrite2 = 1'b1; regDst2 = 4'd5; bus2_w = 32'h55550002;
        regSrc1 = 4'd1; regSrc2 = 4'd2;
        step();
        idle(); regSrc1 = 4'd3; regSrc2 = 4'd5;
        #2;
        chk("dual.r3", outA1, 32'hAAAA0001);
        chk("dual.r5", outB2, 32'h55550002);
        step();

        // Same-address collision: port 1 wins, conflict for one cycle
        regWrite = 1'b1;  regDst1 = 4'd7; bus_w  = 32'h11;
        regWrite2 = 1'b1; regDst2 = 4'd7; bus2_w = 32'h22;
        step();
        chk("conf.set", {31'b0, confA}, 32'h1);
        idle(); regSrc1 = 4'd7;
        #2;
        chk("conf.r7", outB1, 32'h11);
        step();
        chk("conf.clr", {31'b0, confA}, 32'h0);

        // Bypass vs registered read on address 9
        regWrite = 1'b1; regDst1 = 4'd9; bus_w = 32'h1234;
        step();
        idle(); regSrc1 = 4'd9;
        regWrite2 = 1'b1; regDst2 = 4'd9; bus2_w = 32'hDEAD;
        #2;
        chk("byp.A", outA1, 32'hDEAD);
        chk("byp.B", outB1, 32'h1234);
        step();

        // Scoreboard: mark, clear by write, mark+write keeps pending
        idle(); mark = 1'b1; markDst = 4'd4;
        step();
        idle(); regSrc1 = 4'd4;
        #2; chk("sb.marked", {31'b0, busyA1}, 32'h1);
        step();
        regWrite = 1'b1; regDst1 = 4'd4; bus_w = 32'h44;
        #2; chk("sb.bypclr", {31'b0, busyA1}, 32'h0);
        step();
        idle();
        #2; chk("sb.clr", {31'b0, busyA1}, 32'h0);
        step();
        regWrite = 1'b1; regDst1 = 4'd4; bus_w = 32'h45; mark = 1'b1; markDst = 4'd4;
        step();
        idle();
        #2; chk("sb.newprod", {31'b0, busyA1}, 32'h1);
        step();

        // Address 0 handling, then reset overriding a write and marks
        regWrite = 1'b1; regDst1 = 4'd0; bus_w = 32'hFFFF; mark = 1'b1; markDst = 4'd0;
        regSrc1 = 4'd0;
        step();
        idle();
        #2;
        chk("z.out", outB1, 32'h0);
        chk("z.busy", {31'b0, busyB1}, 32'h0);
        step();
        regWrite = 1'b1; regDst1 = 4'd2; bus_w = 32'h5;
        mark = 1'b1; markDst = 4'd6;
        step();
        rst = 1'b1; regWrite = 1'b1; regDst1 = 4'd2; bus_w = 32'h77;
        mark = 1'b1; markDst = 4'd8; regSrc1 = 4'd1; regSrc2 = 4'd1;
        step();
        idle(); regSrc1 = 4'd2;
        #2; chk("rst.r2", outA1, 32'h0);
        step();
        for (int s = 0; s < 16; s++) begin
            regSrc1 = 4'(s); regSrc2 = 4'(s);
            step();
        end

        // Random traffic with biased collisions
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 49) == 0);
            regWrite  = $urandom_range(0, 1) == 1;
            regWrite2 = $urandom_range(0, 1) == 1;
            mark      = $urandom_range(0, 2) == 0;
            regDst1   = 4'($urandom_range(0, 15));
            regDst2   = ($urandom_range(0, 7) == 0) ? regDst1 : 4'($urandom_range(0, 15));
            markDst   = ($urandom_range(0, 3) == 0) ? regDst1 : 4'($urandom_range(0, 15));
            regSrc1   = ($urandom_range(0, 3) == 0) ? regDst2 : 4'($urandom_range(0, 15));
            regSrc2   = ($urandom_range(0, 3) == 0) ? regDst1 : 4'($urandom_range(0, 15));
            bus_w     = $urandom;
            bus2_w    = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", passCount, total);
        $finish;
    end

endmodule
